// File: rtl/hamming_serial_encoder_param.sv
// Serial Hamming / SECDED encoder with ready/valid on both sides.
// Input bits are gathered MSB first into a collection buffer. The full block is
// encoded and handed to a separate output shift stage, so the next block can be
// collected while the current codeword streams out.
module hamming_serial_encoder_param #(
  parameter int DATA_W  = 32,
  parameter int PAR_W   = 6,
  parameter int EXT_PAR = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             data_in,
  input  logic             data_valid,
  output logic             data_in_ready,
  output logic             data_out,
  output logic             data_out_valid,
  input  logic             data_out_ready,
  output logic             data_out_last,
  output logic [CNT_W-1:0] blk_cnt
);

  localparam int N_H    = DATA_W + PAR_W;
  localparam int CODE_W = N_H + EXT_PAR;
  localparam int IN_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int OUT_W  = $clog2(CODE_W);
  localparam logic [IN_W-1:0]  IN_LAST  = IN_W'(DATA_W - 1);
  localparam logic [OUT_W-1:0] OUT_LAST = OUT_W'(CODE_W - 1);

  generate
    if (DATA_W < 1) begin : g_badDataW
      $error("hamming_serial_encoder_param: DATA_W must be at least 1");
    end
    if ((2 ** PAR_W) < (DATA_W + PAR_W + 1)) begin : g_badParW
      $error("hamming_serial_encoder_param: PAR_W too small for DATA_W");
    end
  endgenerate

  typedef enum logic {COLLECT, FULL} inState_t;
  typedef enum logic {IDLE, SEND} outState_t;

  inState_t          r_inState;
  inState_t          w_inNext;
  outState_t         r_outState;
  outState_t         w_outNext;
  logic [IN_W-1:0]   r_inCnt;
  logic [DATA_W-1:0] r_dataBuf;
  logic [CODE_W-1:0] r_outShift;
  logic [OUT_W-1:0]  r_outIdx;
  logic [CNT_W-1:0]  r_blkCnt;
  logic [CODE_W-1:0] w_code;
  logic              w_inAccept;
  logic              w_outAdvance;
  logic              w_lastHs;
  logic              w_load;

  // Codeword bit 0 is Hamming position 1 (sent first). Data fills the
  // non-power-of-two positions in ascending order, oldest bit first, then each
  // parity bit covers the positions whose index has its bit set.
  function automatic logic [CODE_W-1:0] encodeBlock(input logic [DATA_W-1:0] d);
    logic [CODE_W-1:0] c;
    logic              p;
    int                k;
    c = '0;
    k = DATA_W - 1;
    for (int pos = 1; pos <= N_H; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        c[pos-1] = d[k];
        k--;
      end
    end
    for (int i = 0; i < PAR_W; i++) begin
      p = 1'b0;
      for (int pos = 1; pos <= N_H; pos++) begin
        if (((pos >> i) & 1) == 1) p = p ^ c[pos-1];
      end
      if ((1 << i) <= N_H) c[(1 << i) - 1] = p;
    end
    if (EXT_PAR != 0) c[CODE_W-1] = ^c[N_H-1:0];
    return c;
  endfunction

  assign w_inAccept   = data_valid && (r_inState == COLLECT);
  assign w_outAdvance = (r_outState == SEND) && data_out_ready;
  assign w_lastHs     = w_outAdvance && (r_outIdx == OUT_LAST);
  assign w_load       = (r_inState == FULL) && ((r_outState == IDLE) || w_lastHs);

  // Encode the held block combinationally; it is only sampled on a transfer.
  always_comb begin
    w_code = encodeBlock(r_dataBuf);
  end

  // State registers for the input and output FSMs.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_inState  <= COLLECT;
      r_outState <= IDLE;
    end else begin
      r_inState  <= w_inNext;
      r_outState <= w_outNext;
    end
  end

  // Next-state logic; a final-bit handshake with a full input reloads with no gap.
  always_comb begin
    w_inNext  = r_inState;
    w_outNext = r_outState;
    case (r_inState)
      COLLECT: if (w_inAccept && (r_inCnt == IN_LAST)) w_inNext = FULL;
      FULL:    if (w_load) w_inNext = COLLECT;
      default: w_inNext = COLLECT;
    endcase
    case (r_outState)
      IDLE:    if (w_load) w_outNext = SEND;
      SEND:    if (w_lastHs) w_outNext = w_load ? SEND : IDLE;
      default: w_outNext = IDLE;
    endcase
  end

  // Port outputs decoded from state and the output shift register.
  always_comb begin
    data_in_ready  = (r_inState == COLLECT);
    data_out_valid = (r_outState == SEND);
    data_out       = r_outShift[0];
    data_out_last  = (r_outState == SEND) && (r_outIdx == OUT_LAST);
    blk_cnt        = r_blkCnt;
  end

  // Collection buffer: shift accepted bits in so the first one ends at the MSB.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_inCnt   <= '0;
      r_dataBuf <= '0;
    end else if (w_inAccept) begin
      r_dataBuf <= DATA_W'({r_dataBuf, data_in});
      r_inCnt   <= (r_inCnt == IN_LAST) ? '0 : r_inCnt + 1'b1;
    end
  end

  // Output stage: load a fresh codeword or shift one bit per handshake.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_outShift <= '0;
      r_outIdx   <= '0;
    end else if (w_load) begin
      r_outShift <= w_code;
      r_outIdx   <= '0;
    end else if (w_outAdvance) begin
      r_outShift <= r_outShift >> 1;
      r_outIdx   <= r_outIdx + 1'b1;
    end
  end

  // Count completed codewords; wraps naturally at the counter width.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_blkCnt <= '0;
    end else if (w_lastHs) begin
      r_blkCnt <= r_blkCnt + 1'b1;
    end
  end

endmodule
